// File: rtl/div_radix2_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle; DIV_EARLY_OUT_EN enables dividend<divisor bypass.
// Latency: valid in cycle XLEN+1 after start is accepted (cycle 1 on early out), plus one per held cycle.
// Backpressure: hold freezes all state and outputs; dropping start while BUSY aborts the operation.
module div_radix2_iter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            hold,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            start,
   output logic            valid,
   output logic [XLEN-1:0] q,
   output logic [XLEN-1:0] rem
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  a;        // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]  d;
   // The restored remainder is always below D, so its top bit is zero and is not stored.
   logic [XLEN-1:0]  r;

   logic [XLEN:0]    t;
   logic [XLEN-1:0]  t_sub;
   logic             qbit;
   logic [XLEN-1:0]  r_nxt;
   logic [XLEN-1:0]  a_nxt;
   logic             accept;
   logic             early;
   logic             last;

   // One restoring iteration: shift in next dividend bit, trial-subtract D.
   always_comb begin
      t     = {r, a[XLEN-1]};
      qbit  = (t >= {1'b0, d});
      // Only used when qbit=1, where the true difference fits in XLEN bits.
      t_sub = t[XLEN-1:0] - d;
      r_nxt = qbit ? t_sub : t[XLEN-1:0];
      a_nxt = {a[XLEN-2:0], qbit};
   end

   // Next-state and control decode; hold is applied at the register.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      early     = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = BUSY;
`ifdef DIV_EARLY_OUT_EN
               if (dividend < divisor) begin
                  early     = 1'b1;
                  state_nxt = DONE;
               end
`endif
            end
         end
         BUSY: begin
            if (!start) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_W'(1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset wins over hold.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else if (!hold) begin
         state <= state_nxt;
      end
   end

   // Operand latch, iteration datapath and registered results.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt   <= '0;
         a     <= '0;
         d     <= '0;
         r     <= '0;
         q     <= '0;
         rem   <= '0;
         valid <= 1'b0;
      end else if (!hold) begin
         valid <= (state_nxt == DONE);
         if (accept) begin
            d   <= divisor;
            a   <= dividend;
            r   <= '0;
            cnt <= CNT_W'(XLEN);
         end else if (state == BUSY && start) begin
            a   <= a_nxt;
            r   <= r_nxt;
            cnt <= cnt - CNT_W'(1);
         end
         if (last) begin
            q   <= a_nxt;
            rem <= r_nxt;
         end
         if (early) begin
            q   <= '0;
            rem <= dividend;
         end
      end
   end

endmodule

// File: tb/tb_div_radix2_iter.sv
module tb_div_radix2_iter;
   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            hold = 1'b0;
   logic [XLEN-1:0] dividend = '0;
   logic [XLEN-1:0] divisor = '0;
   logic            start = 1'b0;
   logic            valid;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] rem;

   int total = 0;
   int bad = 0;
   logic [XLEN-1:0] last_q = '0;
   logic [XLEN-1:0] last_r = '0;

   div_radix2_iter #(.XLEN(XLEN), .CNT_W(7)) dut (
      .clk(clk), .rstn(rstn), .hold(hold), .dividend(dividend), .divisor(divisor),
      .start(start), .valid(valid), .q(q), .rem(rem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain unsigned division; divide-by-zero gives all ones and the dividend.
   function automatic logic [XLEN-1:0] ref_q(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
      return (y == 0) ? '1 : x / y;
   endfunction
   function automatic logic [XLEN-1:0] ref_r(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
      return (y == 0) ? x : x % y;
   endfunction
   function automatic int base_lat(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
`ifdef DIV_EARLY_OUT_EN
      if (x < y) return 1;
`endif
      return XLEN + 1;
   endfunction

   // Called at a negedge with the core in IDLE; this cycle becomes cycle 0.
   task automatic op(input string tag, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                     input int exp_first, input int exp_nv, input int hold_at, input int hold_len);
      int first = -1;
      int nv = 0;
      logic [XLEN-1:0] eq = ref_q(x, y);
      logic [XLEN-1:0] er = ref_r(x, y);
      dividend = x;
      divisor  = y;
      start    = 1'b1;
      hold     = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid) begin
            if (first < 0) first = cyc;
            nv++;
            chk({tag, "_q"}, q, eq);
            chk({tag, "_rem"}, rem, er);
            start = 1'b0;
         end else if (first >= 0) begin
            break;
         end
         hold = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      end
      hold  = 1'b0;
      start = 1'b0;
      chk({tag, "_lat"}, 64'(first), 64'(exp_first));
      chk({tag, "_vcnt"}, 64'(nv), 64'(exp_nv));
      chk({tag, "_keep_q"}, q, eq);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      logic [XLEN-1:0] x, y;
      int ha, hl, lat;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_q", q, 64'd0);
      chk("rst_rem", rem, 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      op("basic", 64'd100, 64'd7, base_lat(64'd100, 64'd7), 1, 0, 0);
      chk("basic_val", last_q, 64'd14);
      op("full", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, XLEN + 1, 1, 0, 0);
      op("div0", 64'h1234, 64'd0, XLEN + 1, 1, 0, 0);
      op("hold_busy", 64'd987654321, 64'd12345, XLEN + 1 + 5, 1, 10, 5);
      op("hold_done", 64'hDEAD_BEEF_0000_1111, 64'd3, XLEN + 1, 4, XLEN + 1, 3);
      op("early", 64'd5, 64'd9, base_lat(64'd5, 64'd9), 1, 0, 0);

      // Abort: start dropped in cycle 20, core must return to IDLE silently.
      dividend = 64'd1000;
      divisor  = 64'd3;
      start    = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 20 || c == 21 || c == 22) chk("abort_novalid", 64'(valid), 64'd0);
         if (c == 20) start = 1'b0;
      end
      chk("abort_keep_q", q, last_q);
      chk("abort_keep_rem", rem, last_r);
      op("after_abort", 64'd1_000_003, 64'd10, XLEN + 1, 1, 0, 0);

      // Reset mid-operation in cycle 30.
      dividend = 64'd77777;
      divisor  = 64'd5;
      start    = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", 64'(valid), 64'd0);
      chk("midrst_q", q, 64'd0);
      chk("midrst_rem", rem, 64'd0);
      rstn  = 1'b1;
      start = 1'b0;
      @(negedge clk);
      op("after_rst", 64'd77777, 64'd5, XLEN + 1, 1, 0, 0);

      // Random operands with occasional small divisors and random mid-BUSY stalls.
      for (int i = 0; i < 24; i++) begin
         x = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: y = 64'($urandom_range(0, 15));
            1: y = {32'd0, $urandom};
            2: y = {$urandom, $urandom};
            default: y = x >> $urandom_range(0, 63);
         endcase
         if ($urandom_range(0, 3) == 0) x = 64'($urandom_range(0, 20));
         lat = base_lat(x, y);
         ha = $urandom_range(2, 55);
         hl = (lat == 1) ? 0 : $urandom_range(0, 4);
         op("rand", x, y, lat + hl, 1, ha, hl);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_radix2_iter.md
# div_radix2_iter

Iterative unsigned radix-2 restoring divider core that sits directly downstream of the RISC-V divide front end. The front end passes operands already made non-negative, together with a level `start`. This core latches the operands, produces one quotient bit per cycle, and returns quotient, remainder and a `valid` flag. Sign fix-up, divide-by-zero and overflow results are handled upstream; this core only divides. It is pin-compatible with the front end's divider slot, so it can drop in as the non-SRT, area-optimised option.

## Interface
- `XLEN`, default 64: operand, quotient and remainder width (32 for RV32 builds).
- `CNT_W`, default 7: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- `clk`  in  1  core clock. Single clock domain; all logic is on the rising edge.
- `rstn`  in  1  reset. Synchronous, active-low.
- `hold`  in  1  pipeline stall. While high, all internal state and outputs are frozen.
- `dividend`  in  XLEN  unsigned dividend. Sampled only when an operation is accepted.
- `divisor`  in  XLEN  unsigned divisor. Sampled only when an operation is accepted.
- `start`  in  1  level request from the front end. Must stay high until `valid` is seen.
- `valid`  out  1  result valid. Registered, and high only in DONE.
- `q`  out  XLEN  quotient. Registered.
- `rem`  out  XLEN  remainder. Registered.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Every transition below applies only when `hold`=0. When `hold`=1, nothing changes.
- IDLE:
  - If `start`=1: latch `divisor` into D and `dividend` into the shift register A. Clear the partial remainder R (XLEN+1 bits). Set cnt=XLEN. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, one iteration per cycle:
  - Form T = {R[XLEN-1:0], A[XLEN-1]}.
  - If T ≥ {1'b0, D}: R = T − D and the new quotient bit is 1.
  - Otherwise: R = T and the new quotient bit is 0.
  - Shift A left by one and insert the quotient bit at A[0]; A therefore accumulates the quotient.
  - Decrement cnt. When cnt reaches 1, this iteration is the last one: load `q`=final A and `rem`=final R[XLEN-1:0], then go to DONE.
- BUSY abort: if `start`=0 during BUSY (front-end flush), go to IDLE on the next edge. `q` and `rem` are not updated and `valid` never rises.
- DONE:
  - `valid`=1.
  - Go to IDLE on the next non-held edge, regardless of `start`. The front end drops `start` combinationally once it sees `valid`.
- Divisor 0 gives no error. The algorithm naturally yields `q`=all ones and `rem`=`dividend`.
- `q` and `rem` keep their last value until the next completion.
- Reset (`rstn`=0 at an edge), from any state including mid-BUSY and DONE:
  - State goes to IDLE.
  - `valid`=0, `q`=0, `rem`=0, cnt=0, A/R/D=0.
  - Any in-flight operation is discarded.

## Timing
- Call cycle 0 the cycle in which `start`=1 is sampled in IDLE.
- BUSY occupies cycles 1..XLEN.
- `valid` is high in cycle XLEN+1: cycle 65 for XLEN=64, cycle 33 for XLEN=32.
- Each held cycle adds one cycle of latency; no iteration is lost or duplicated.
- `valid` lasts exactly one non-held cycle. While `hold`=1 in DONE, `valid`, `q` and `rem` stay stable.
- Back-to-back operations: after DONE, the core spends one IDLE cycle, then accepts a new `start`.
- `start` and `hold` high together in IDLE: the operation is not accepted until `hold` falls.
- `rstn` low takes priority over `hold`.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE with `start`=1, if `dividend` < `divisor` (unsigned, so divisor ≠ 0), skip BUSY.
  - Load `q`=0 and `rem`=`dividend`, and go straight to DONE. `valid` is high in cycle 1.
- `DIV_EARLY_OUT_EN` undefined: every operation takes the full XLEN+1 cycles. This is the default for cycle-deterministic builds.

## Test plan
- Basic division, XLEN=64: `dividend`=100, `divisor`=7, `start` held high → `valid` in cycle 65 with `q`=14, `rem`=2; `valid` is low in cycle 66.
- Full-width operands: `dividend`=0xFFFF_FFFF_FFFF_FFFF, `divisor`=0x1_0000_0000 → `q`=0xFFFF_FFFF, `rem`=0xFFFF_FFFF.
- Divide by zero: `dividend`=0x1234, `divisor`=0 → `q`=all ones, `rem`=0x1234 in cycle 65.
- Hold behaviour:
  - `hold`=1 for 5 cycles mid-BUSY → `valid` in cycle 70 with correct result.
  - `hold`=1 during DONE for 3 cycles → `valid`, `q` and `rem` stay stable for 4 cycles.
- Abort and reset:
  - `start` dropped at cycle 20 → IDLE in cycle 21 with no `valid`; a new op started in cycle 22 completes correctly.
  - `rstn`=0 at cycle 30 → all outputs 0 on the next cycle.
- Early out (`DIV_EARLY_OUT_EN` on): `dividend`=5, `divisor`=9 → `valid` in cycle 1 with `q`=0, `rem`=5. With the macro off, the same stimulus gives `valid` in cycle 65 with the same result.
